uart_rx_capture_ctrl: RTL and testbench

- Controller between the UART receiver (`read`) and the 7-segment display path.
- Configures the receiver and gates Rx_Enable for flow control.
- Screens each completed frame for errors and logs good bytes into a 16-entry ring buffer.
- Scans the stored bytes one at a time onto a display byte output, with a programmable dwell time per entry.

---
 rtl/uart_rx_capture_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_capture_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_capture_ctrl.sv
// UART receive capture: flow control, 16-entry byte log, display scan.
// Optional RX_ERR_STORE_EN: keep errored frames, tagged, in the log.
module uart_rx_capture_ctrl #(
    parameter int         DWELL      = 50000000,
    parameter logic [1:0] BIT_LENGTH = 2'b11,
    parameter logic       PARITY_EN  = 1'b0,
    parameter logic       ODD_PARITY = 1'b0
) (
    input  logic       m_clock,
    input  logic       p_reset,
    input  logic       rx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_parity_err_i,
    input  logic       rx_framing_err_i,
    input  logic       rx_operation_i,
    output logic       rx_enable_o,
    output logic [1:0] rx_bitlength_o,
    output logic       rx_parityen_o,
    output logic       rx_oddparity_o,
    input  logic       clear_i,
    input  logic       pop_i,
    input  logic       hold_i,
    output logic [4:0] count_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] err_cnt_o,
    output logic [7:0] ovf_cnt_o,
    output logic       disp_valid_o,
    output logic [3:0] disp_idx_o,
    output logic [7:0] disp_data_o,
    output logic       disp_err_o
);

    localparam int DW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {RUN, DRAIN, STOP} flow_t;
    typedef enum logic {SCAN_IDLE, SCAN_SHOW} scan_t;

    logic [7:0]    r_mem [16];
    logic [3:0]    r_wr_ptr, r_rd_ptr;
    logic [4:0]    r_count;
    logic [7:0]    r_err_cnt, r_ovf_cnt;
    flow_t         r_flow, w_flow_nxt;
    logic          r_rx_enable;
    scan_t         r_scan, w_scan_nxt;
    logic [3:0]    r_pos, w_pos_nxt;
    logic [DW-1:0] r_dwell, w_dwell_nxt;
    logic          r_disp_valid;
    logic [3:0]    r_disp_idx;
    logic [7:0]    r_disp_data;

    logic w_err, w_full, w_empty, w_wr, w_pop, w_err_inc, w_ovf_inc;
    logic [3:0] w_disp_addr;

    assign w_err   = rx_parity_err_i | rx_framing_err_i;
    assign w_full  = (r_count == 5'd16);
    assign w_empty = (r_count == 5'd0);
    assign w_pop   = pop_i & ~w_empty & ~clear_i;
    assign w_disp_addr = r_rd_ptr + r_pos;

`ifdef RX_ERR_STORE_EN
    logic [15:0] r_tag;
    logic        r_disp_err;

    assign w_wr      = rx_ready_i & ~w_full & ~clear_i;
    assign w_err_inc = rx_ready_i & w_err & ~w_full & ~clear_i;
    assign w_ovf_inc = rx_ready_i & w_full & ~clear_i;

    always_ff @(posedge m_clock) begin
        if (w_wr) r_tag[r_wr_ptr] <= w_err;
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset)                           r_disp_err <= 1'b0;
        else if (clear_i || r_scan == SCAN_IDLE) r_disp_err <= 1'b0;
        else                                    r_disp_err <= r_tag[w_disp_addr];
    end

    assign disp_err_o = r_disp_err;
`else
    // Errors take precedence over full: an errored frame never counts as overflow.
    assign w_wr      = rx_ready_i & ~w_err & ~w_full & ~clear_i;
    assign w_err_inc = rx_ready_i & w_err & ~clear_i;
    assign w_ovf_inc = rx_ready_i & ~w_err & w_full & ~clear_i;
    assign disp_err_o = 1'b0;
`endif

    always_ff @(posedge m_clock) begin
        if (w_wr) r_mem[r_wr_ptr] <= rx_data_i;
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_wr_ptr  <= 4'd0;
            r_rd_ptr  <= 4'd0;
            r_count   <= 5'd0;
            r_err_cnt <= 8'd0;
            r_ovf_cnt <= 8'd0;
        end else if (clear_i) begin
            r_wr_ptr  <= 4'd0;
            r_rd_ptr  <= 4'd0;
            r_count   <= 5'd0;
            r_err_cnt <= 8'd0;
            r_ovf_cnt <= 8'd0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 4'd1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 4'd1;
            if (w_wr && !w_pop)      r_count <= r_count + 5'd1;
            else if (!w_wr && w_pop) r_count <= r_count - 5'd1;
            if (w_err_inc && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (w_ovf_inc && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    always_comb begin
        w_flow_nxt = r_flow;
        if (clear_i) begin
            w_flow_nxt = RUN;
        end else begin
            unique case (r_flow)
                RUN:     if (w_full) w_flow_nxt = DRAIN;
                DRAIN:   if (!w_full) w_flow_nxt = RUN;
                         else if (!rx_operation_i) w_flow_nxt = STOP;
                STOP:    if (!w_full) w_flow_nxt = RUN;
                default: w_flow_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_flow      <= RUN;
            r_rx_enable <= 1'b1;
        end else begin
            r_flow      <= w_flow_nxt;
            r_rx_enable <= (w_flow_nxt != STOP);
        end
    end

    always_comb begin
        w_scan_nxt  = r_scan;
        w_pos_nxt   = r_pos;
        w_dwell_nxt = r_dwell;
        if (clear_i) begin
            w_scan_nxt  = SCAN_IDLE;
            w_pos_nxt   = 4'd0;
            w_dwell_nxt = '0;
        end else begin
            unique case (r_scan)
                SCAN_IDLE: begin
                    w_pos_nxt   = 4'd0;
                    w_dwell_nxt = '0;
                    if (!w_empty) w_scan_nxt = SCAN_SHOW;
                end
                SCAN_SHOW: begin
                    if (w_empty) begin
                        w_scan_nxt  = SCAN_IDLE;
                        w_pos_nxt   = 4'd0;
                        w_dwell_nxt = '0;
                    end else if (w_pop) begin
                        w_pos_nxt   = 4'd0;
                        w_dwell_nxt = '0;
                    end else if (!hold_i) begin
                        if (r_dwell == LAST) begin
                            w_dwell_nxt = '0;
                            w_pos_nxt = (({1'b0, r_pos} + 5'd1) >= r_count) ?
                                        4'd0 : r_pos + 4'd1;
                        end else begin
                            w_dwell_nxt = r_dwell + 1'b1;
                        end
                    end
                end
                default: w_scan_nxt = SCAN_IDLE;
            endcase
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_scan       <= SCAN_IDLE;
            r_pos        <= 4'd0;
            r_dwell      <= '0;
            r_disp_valid <= 1'b0;
            r_disp_idx   <= 4'd0;
            r_disp_data  <= 8'd0;
        end else begin
            r_scan  <= w_scan_nxt;
            r_pos   <= w_pos_nxt;
            r_dwell <= w_dwell_nxt;
            if (clear_i || r_scan == SCAN_IDLE) begin
                r_disp_valid <= 1'b0;
                r_disp_idx   <= 4'd0;
                r_disp_data  <= 8'd0;
            end else begin
                r_disp_valid <= 1'b1;
                r_disp_idx   <= r_pos;
                r_disp_data  <= r_mem[w_disp_addr];
            end
        end
    end

    assign rx_enable_o    = r_rx_enable;
    assign rx_bitlength_o = BIT_LENGTH;
    assign rx_parityen_o  = PARITY_EN;
    assign rx_oddparity_o = ODD_PARITY;
    assign count_o        = r_count;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign err_cnt_o      = r_err_cnt;
    assign ovf_cnt_o      = r_ovf_cnt;
    assign disp_valid_o   = r_disp_valid;
    assign disp_idx_o     = r_disp_idx;
    assign disp_data_o    = r_disp_data;

endmodule

// File: tb/tb_uart_rx_capture_ctrl.sv
// Directed bench for uart_rx_capture_ctrl (default build, DWELL=4).
module tb_uart_rx_capture_ctrl;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b0;
    logic       rx_ready_i = 1'b0;
    logic [7:0] rx_data_i = 8'd0;
    logic       rx_parity_err_i = 1'b0;
    logic       rx_framing_err_i = 1'b0;
    logic       rx_operation_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       pop_i = 1'b0;
    logic       hold_i = 1'b0;
    logic       rx_enable_o;
    logic [1:0] rx_bitlength_o;
    logic       rx_parityen_o;
    logic       rx_oddparity_o;
    logic [4:0] count_o;
    logic       full_o;
    logic       empty_o;
    logic [7:0] err_cnt_o;
    logic [7:0] ovf_cnt_o;
    logic       disp_valid_o;
    logic [3:0] disp_idx_o;
    logic [7:0] disp_data_o;
    logic       disp_err_o;

    int n_run = 0;
    int n_fail = 0;

    uart_rx_capture_ctrl #(.DWELL(4)) dut (
        .m_clock(m_clock), .p_reset(p_reset),
        .rx_ready_i(rx_ready_i), .rx_data_i(rx_data_i),
        .rx_parity_err_i(rx_parity_err_i), .rx_framing_err_i(rx_framing_err_i),
        .rx_operation_i(rx_operation_i), .rx_enable_o(rx_enable_o),
        .rx_bitlength_o(rx_bitlength_o), .rx_parityen_o(rx_parityen_o),
        .rx_oddparity_o(rx_oddparity_o), .clear_i(clear_i), .pop_i(pop_i),
        .hold_i(hold_i), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
        .err_cnt_o(err_cnt_o), .ovf_cnt_o(ovf_cnt_o),
        .disp_valid_o(disp_valid_o), .disp_idx_o(disp_idx_o),
        .disp_data_o(disp_data_o), .disp_err_o(disp_err_o)
    );

    always #5 m_clock = ~m_clock;

    typedef struct packed {
        logic       rdy;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       pop;
        logic       clr;
        logic [4:0] c;
        logic [7:0] e;
        logic [7:0] o;
        logic       emp;
        logic       full;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic frame(input logic [7:0] d, input logic pe, input logic fe);
        rx_ready_i = 1'b1;
        rx_data_i = d;
        rx_parity_err_i = pe;
        rx_framing_err_i = fe;
        tick();
        rx_ready_i = 1'b0;
        rx_parity_err_i = 1'b0;
        rx_framing_err_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        int hidx;
        int hdat;
        int k;
        //        rdy  data   pe   fe   pop  clr  cnt  err    ovf   emp  full
        vt[0]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd1, 8'd0, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd2, 8'd0, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd2, 8'd0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'd2, 8'd0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 8'd2, 8'd0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 8'd3, 8'd0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 8'd3, 8'd0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 8'd3, 8'd0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd3, 8'd0, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'd0, 8'd0, 1'b1, 1'b0};
        vt[10] = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'd0, 8'd0, 1'b0, 1'b0};
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 8'd0, 8'd0, 1'b1, 1'b0};

        // reset state
        tick();
        tick();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_rxen", rx_enable_o, 1);
        chk("rst_err", err_cnt_o, 0);
        chk("rst_ovf", ovf_cnt_o, 0);
        chk("rst_dvalid", disp_valid_o, 0);
        chk("rst_didx", disp_idx_o, 0);
        chk("rst_ddata", disp_data_o, 0);
        chk("rst_derr", disp_err_o, 0);
        chk("cfg_bitlen", rx_bitlength_o, 3);
        chk("cfg_paren", rx_parityen_o, 0);
        chk("cfg_odd", rx_oddparity_o, 0);
        p_reset = 1'b1;
        tick();

        // table-driven counter vectors
        for (int i = 0; i < 12; i++) begin
            rx_ready_i = vt[i].rdy;
            rx_data_i = vt[i].d;
            rx_parity_err_i = vt[i].pe;
            rx_framing_err_i = vt[i].fe;
            pop_i = vt[i].pop;
            clear_i = vt[i].clr;
            tick();
            chk($sformatf("v%0d_count", i), count_o, vt[i].c);
            chk($sformatf("v%0d_err", i), err_cnt_o, vt[i].e);
            chk($sformatf("v%0d_ovf", i), ovf_cnt_o, vt[i].o);
            chk($sformatf("v%0d_empty", i), empty_o, vt[i].emp);
            chk($sformatf("v%0d_full", i), full_o, vt[i].full);
        end
        rx_ready_i = 1'b0;
        rx_parity_err_i = 1'b0;
        rx_framing_err_i = 1'b0;
        pop_i = 1'b0;
        clear_i = 1'b0;
        tick();
        tick();
        chk("errs_dvalid", disp_valid_o, 0);

        // display scan with dwell of 4
        frame(8'h41, 1'b0, 1'b0);
        frame(8'h42, 1'b0, 1'b0);
        frame(8'h43, 1'b0, 1'b0);
        chk("scan_count", count_o, 3);
        k = 0;
        while (!disp_valid_o && k < 20) begin
            tick();
            k++;
        end
        chk("scan_valid_seen", disp_valid_o, 1);
        for (int s = 0; s < 16; s++) begin
            int p;
            p = (s / 4) % 3;
            chk($sformatf("scan%0d_data", s), disp_data_o, 8'h41 + p);
            chk($sformatf("scan%0d_idx", s), disp_idx_o, p);
            tick();
        end

        // hold freezes the scan
        hold_i = 1'b1;
        tick();
        hidx = disp_idx_o;
        hdat = disp_data_o;
        for (int s = 0; s < 9; s++) tick();
        chk("hold_idx", disp_idx_o, hidx);
        chk("hold_data", disp_data_o, hdat);
        hold_i = 1'b0;

        // same-cycle write and pop with count=5
        do_clear();
        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b0, 1'b0);
        chk("wp_pre_count", count_o, 5);
        k = 0;
        while (disp_idx_o != 4'd2 && k < 100) begin
            tick();
            k++;
        end
        chk("wp_idx2_seen", disp_idx_o, 2);
        rx_ready_i = 1'b1;
        rx_data_i = 8'h10;
        pop_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        pop_i = 1'b0;
        chk("wp_count", count_o, 5);
        tick();
        chk("wp_restart_idx", disp_idx_o, 0);
        chk("wp_restart_data", disp_data_o, 2);
        pop_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        pop_i = 1'b0;
        chk("wp_count1", count_o, 1);
        tick();
        tick();
        chk("wp_newest", disp_data_o, 8'h10);

        // fill to full, overflow, flow control
        do_clear();
        rx_operation_i = 1'b0;
        for (int i = 0; i < 16; i++) frame(8'h20 + 8'(i), 1'b0, 1'b0);
        chk("full_count", count_o, 16);
        chk("full_flag", full_o, 1);
        frame(8'h99, 1'b0, 1'b0);
        chk("ovf_cnt", ovf_cnt_o, 1);
        chk("ovf_count", count_o, 16);
        frame(8'h98, 1'b1, 1'b0);
        chk("fullerr_err", err_cnt_o, 1);
        chk("fullerr_ovf", ovf_cnt_o, 1);
        tick();
        tick();
        chk("full_rxen", rx_enable_o, 0);
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        chk("pop_count", count_o, 15);
        tick();
        chk("pop_rxen", rx_enable_o, 1);
        frame(8'h77, 1'b0, 1'b0);
        chk("refill_count", count_o, 16);
        rx_ready_i = 1'b1;
        rx_data_i = 8'h88;
        pop_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
        pop_i = 1'b0;
        chk("fullpop_count", count_o, 15);
        chk("fullpop_ovf", ovf_cnt_o, 2);

        // drain holds enable until the frame in progress ends
        do_clear();
        rx_operation_i = 1'b1;
        for (int i = 0; i < 16; i++) frame(8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("drain_rxen", rx_enable_o, 1);
        rx_operation_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("drain_stop", rx_enable_o, 0);

        // clear beats same-cycle frame and pop
        do_clear();
        chk("clr_rxen", rx_enable_o, 1);
        for (int i = 0; i < 7; i++) frame(8'hC0 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) frame(8'hE0, 1'b0, 1'b1);
        chk("clr_pre_count", count_o, 7);
        chk("clr_pre_err", err_cnt_o, 3);
        clear_i = 1'b1;
        rx_ready_i = 1'b1;
        rx_data_i = 8'hF0;
        pop_i = 1'b1;
        tick();
        clear_i = 1'b0;
        rx_ready_i = 1'b0;
        pop_i = 1'b0;
        chk("clr_count", count_o, 0);
        chk("clr_err", err_cnt_o, 0);
        chk("clr_empty", empty_o, 1);
        tick();
        tick();
        chk("clr_dvalid", disp_valid_o, 0);

        // error counter saturates
        for (int i = 0; i < 260; i++) frame(8'h00, 1'b1, 1'b0);
        chk("err_sat", err_cnt_o, 255);

        // async reset mid-operation drops the in-flight frame
        frame(8'h31, 1'b0, 1'b0);
        frame(8'h32, 1'b0, 1'b0);
        rx_ready_i = 1'b1;
        rx_data_i = 8'h33;
        #2;
        p_reset = 1'b0;
        #1;
        chk("arst_count", count_o, 0);
        chk("arst_err", err_cnt_o, 0);
        tick();
        rx_ready_i = 1'b0;
        p_reset = 1'b1;
        tick();
        chk("arst_after", count_o, 0);
        chk("arst_empty", empty_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
